multi_clip_controller: RTL and testbench
========================================

MULTI_CLIP_CONTROLLER -- requirements
Module: multi_clip_controller

Interface
REQ-001 SHALL have parameter NUM_CLIPS, default 4: number of independent clip memories; minimum 2.
REQ-002 SHALL have parameter ADDR_W, default 16: sample address width; each clip holds up to 2^ADDR_W samples.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: flop depth of each input synchronizer; minimum 2.
REQ-004 SHALL have port clock_i  in  1: 100 MHz clock, the only clock.
REQ-005 SHALL have port reset_i  in  1: reset, synchronous and active-high.
REQ-006 SHALL have port clip_select_i  in  CLIP_W=$clog2(NUM_CLIPS): asynchronous switch selecting the clip.
REQ-007 SHALL have ports play_i, record_i, stop_i  in  1 each: asynchronous button commands.
REQ-008 SHALL have port sample_tick_i  in  1: synchronous one-cycle pulse per audio sample period.
REQ-009 SHALL have ports serializer_enable_o, deserializer_enable_o  out  1 each: playback path enable and record path enable.
REQ-010 SHALL have port mem_enable_o  out  NUM_CLIPS: one-hot per-clip memory strobe.
REQ-011 SHALL have port mem_rw_o  out  1: 1 = write (record), 0 = read (play).
REQ-012 SHALL have port mem_addr_o  out  ADDR_W: sample address within the active clip.
REQ-013 SHALL have ports busy_o, error_o  out  1 each: recording or playing active; error state.

Function
REQ-014 SHALL pass play_i, record_i, stop_i and clip_select_i through SYNC_STAGES flops; command buttons are then rising-edge detected into one-cycle pulses.
REQ-015 SHALL register each command pulse SYNC_STAGES+1 cycles after the input rises, and change state on the following clock edge.
REQ-016 SHALL implement states RESET, IDLE, RECORDING, PLAYING, ERROR; RESET -> IDLE unconditionally after one cycle.
REQ-017 IDLE: record pulse -> RECORDING; play pulse -> PLAYING if length[clip] != 0, else ERROR; record has priority over play in the same cycle.
REQ-018 SHALL latch the synchronized clip index on leaving IDLE; clip_select_i changes mid-operation are ignored.
REQ-019 SHALL clear the address counter to 0 on entering RECORDING or PLAYING.
REQ-020 RECORDING/PLAYING: on each sample_tick_i, pulse mem_enable_o[latched clip] for exactly that cycle with mem_addr_o = counter, then increment the counter.
REQ-021 RECORDING: stop pulse -> IDLE with length[clip] = counter; a counter wrap (2^ADDR_W writes) -> IDLE with length[clip] = 2^ADDR_W.
REQ-022 SHALL keep a length register of ADDR_W+1 bits per clip; a stop before any tick sets the length to 0.
REQ-023 PLAYING: after the read at address length[clip]-1, return to IDLE; a stop pulse -> IDLE immediately.
REQ-024 SHALL ignore play and record pulses while in RECORDING, PLAYING or ERROR.
REQ-025 ERROR: only a stop pulse exits, to IDLE; error_o = 1 only in ERROR.
REQ-026 deserializer_enable_o = 1 only in RECORDING; serializer_enable_o = 1 only in PLAYING; busy_o = either; mem_rw_o = 1 only in RECORDING.
REQ-027 If a stop pulse and sample_tick_i coincide, SHALL perform the tick access first, then stop; for RECORDING the stored length includes that sample.

Reset
REQ-028 reset_i SHALL force state RESET, counter 0, all lengths 0, synchronizers 0, and all outputs 0, including mid-operation.
REQ-029 An operation interrupted by reset SHALL NOT update any length register.

Configuration
REQ-030 With CLIP_LOOP_EN defined, PLAYING SHALL wrap the counter to 0 after address length[clip]-1 and continue until a stop pulse.
REQ-031 Without CLIP_LOOP_EN, playback SHALL end per REQ-023.

Structure
REQ-032 SHALL place the ctrl_state_t enum and the default parameter constants in shared package controller_pkg.
REQ-033 SHALL implement the synchronizer plus rising-edge detector as sub-module sync_edge_detect, instantiated once per command button.

Verification
REQ-034 Record clip 2 with 5 ticks, then stop -> mem_enable_o=4'b0100, mem_rw_o=1, addresses 0..4, length[2]=5, state IDLE.
REQ-035 Play clip 2 after REQ-034 -> 5 reads at addresses 0..4, then IDLE; with CLIP_LOOP_EN, address 0 follows 4 until stop.
REQ-036 Play clip 1 with length 0 -> error_o=1; stop -> IDLE, error_o=0.
REQ-037 ADDR_W=3, record 8 ticks without stop -> auto IDLE, length=8.
REQ-038 play_i and record_i rise in the same cycle -> RECORDING; press play mid-record -> ignored.
REQ-039 reset_i asserted during RECORDING after 3 ticks -> next cycle all outputs 0, length unchanged (0).

Source files
------------

// File: rtl/controller_pkg.sv
// Shared types and default configuration for the multi-clip record/playback controller.
package controller_pkg;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    IDLE      = 3'd1,
    RECORDING = 3'd2,
    PLAYING   = 3'd3,
    ERROR     = 3'd4
  } ctrl_state_t;

  localparam int DEF_NUM_CLIPS   = 4;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous button followed by a registered
// rising-edge detector producing a one-cycle pulse.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Synchronize, remember the previous synchronized level, register the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], button};
      prev  <= sync[SYNC_STAGES-1];
      pulse <= sync[SYNC_STAGES-1] & ~prev;
    end
  end

endmodule

// File: rtl/multi_clip_controller.sv
// Record/playback sequencer for NUM_CLIPS clip memories, one access per sample tick.
// Define CLIP_LOOP_EN to make playback loop over the clip until a stop press.
module multi_clip_controller
  import controller_pkg::*;
#(
  parameter  int NUM_CLIPS   = DEF_NUM_CLIPS,
  parameter  int ADDR_W      = DEF_ADDR_W,
  parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
  localparam int CLIP_W      = $clog2(NUM_CLIPS)
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [CLIP_W-1:0]    clip_select_i,
  input  logic                 play_i,
  input  logic                 record_i,
  input  logic                 stop_i,
  input  logic                 sample_tick_i,
  output logic                 serializer_enable_o,
  output logic                 deserializer_enable_o,
  output logic [NUM_CLIPS-1:0] mem_enable_o,
  output logic                 mem_rw_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 busy_o,
  output logic                 error_o
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(1) << ADDR_W;

  logic [2:0]        buttons;
  logic [2:0]        pulses;
  logic              play_pulse;
  logic              record_pulse;
  logic              stop_pulse;

  logic [CLIP_W-1:0] clip_pipe [SYNC_STAGES];
  logic [CLIP_W-1:0] clip_now;
  logic [CLIP_W-1:0] clip_lat;
  logic [NUM_CLIPS-1:0] clip_onehot;

  ctrl_state_t       state;
  logic [ADDR_W:0]   counter;
  logic [ADDR_W:0]   counter_next;
  logic              wrap_up;
  logic [ADDR_W:0]   length [NUM_CLIPS];

  assign buttons      = {stop_i, record_i, play_i};
  assign play_pulse   = pulses[0];
  assign record_pulse = pulses[1];
  assign stop_pulse   = pulses[2];

  for (genvar g = 0; g < 3; g++) begin : g_button
    sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk    (clock_i),
      .rst    (reset_i),
      .button (buttons[g]),
      .pulse  (pulses[g])
    );
  end

  // Clip selector is a level, so it is only synchronized, not edge detected.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) clip_pipe[i] <= '0;
    end else begin
      clip_pipe[0] <= clip_select_i;
      for (int i = 1; i < SYNC_STAGES; i++) clip_pipe[i] <= clip_pipe[i-1];
    end
  end

  assign clip_now     = clip_pipe[SYNC_STAGES-1];
  assign clip_onehot  = NUM_CLIPS'(1) << clip_lat;
  assign counter_next = counter + (ADDR_W+1)'(1);

  // Controller FSM with registered outputs. A final access (last sample, wrap,
  // or stop coinciding with a tick) sets wrap_up so the strobe is issued while
  // still in the active state; the following cycle returns to IDLE.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state                 <= RESET;
      counter               <= '0;
      clip_lat              <= '0;
      wrap_up               <= 1'b0;
      for (int i = 0; i < NUM_CLIPS; i++) length[i] <= '0;
      serializer_enable_o   <= 1'b0;
      deserializer_enable_o <= 1'b0;
      mem_enable_o          <= '0;
      mem_rw_o              <= 1'b0;
      mem_addr_o            <= '0;
      busy_o                <= 1'b0;
      error_o               <= 1'b0;
    end else begin
      mem_enable_o <= '0;
      case (state)
        RESET: begin
          state <= IDLE;
        end

        IDLE: begin
          counter <= '0;
          wrap_up <= 1'b0;
          if (record_pulse) begin
            state                 <= RECORDING;
            clip_lat              <= clip_now;
            deserializer_enable_o <= 1'b1;
            mem_rw_o              <= 1'b1;
            busy_o                <= 1'b1;
          end else if (play_pulse) begin
            clip_lat <= clip_now;
            if (length[clip_now] != '0) begin
              state               <= PLAYING;
              serializer_enable_o <= 1'b1;
              busy_o              <= 1'b1;
            end else begin
              state   <= ERROR;
              error_o <= 1'b1;
            end
          end
        end

        RECORDING: begin
          if (wrap_up || (stop_pulse && !sample_tick_i)) begin
            length[clip_lat]      <= counter;
            state                 <= IDLE;
            wrap_up               <= 1'b0;
            deserializer_enable_o <= 1'b0;
            mem_rw_o              <= 1'b0;
            busy_o                <= 1'b0;
          end else if (sample_tick_i) begin
            mem_enable_o <= clip_onehot;
            mem_addr_o   <= counter[ADDR_W-1:0];
            counter      <= counter_next;
            if (stop_pulse || (counter_next == FULL_COUNT)) begin
              wrap_up <= 1'b1;
            end
          end
        end

        PLAYING: begin
          if (wrap_up || (stop_pulse && !sample_tick_i)) begin
            state               <= IDLE;
            wrap_up             <= 1'b0;
            serializer_enable_o <= 1'b0;
            busy_o              <= 1'b0;
          end else if (sample_tick_i) begin
            mem_enable_o <= clip_onehot;
            mem_addr_o   <= counter[ADDR_W-1:0];
            if (stop_pulse) begin
              counter <= counter_next;
              wrap_up <= 1'b1;
            end else if (counter_next == length[clip_lat]) begin
`ifdef CLIP_LOOP_EN
              counter <= '0;
`else
              counter <= counter_next;
              wrap_up <= 1'b1;
`endif
            end else begin
              counter <= counter_next;
            end
          end
        end

        ERROR: begin
          if (stop_pulse) begin
            state   <= IDLE;
            error_o <= 1'b0;
          end
        end

        default: begin
          state                 <= IDLE;
          wrap_up               <= 1'b0;
          serializer_enable_o   <= 1'b0;
          deserializer_enable_o <= 1'b0;
          mem_rw_o              <= 1'b0;
          busy_o                <= 1'b0;
          error_o               <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_clip_controller.sv
// Directed bench for multi_clip_controller: a default instance plus an ADDR_W=3
// instance sharing the same stimulus.
module tb_multi_clip_controller;
  import controller_pkg::*;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [1:0]  clip_select_i;
  logic        play_i, record_i, stop_i, sample_tick_i;

  logic        a_ser, a_deser, a_rw, a_busy, a_err;
  logic [3:0]  a_en;
  logic [15:0] a_addr;
  logic        b_ser, b_deser, b_rw, b_busy, b_err;
  logic [3:0]  b_en;
  logic [2:0]  b_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock_i = ~clock_i;

  multi_clip_controller dut_a (
    .clock_i(clock_i), .reset_i(reset_i), .clip_select_i(clip_select_i),
    .play_i(play_i), .record_i(record_i), .stop_i(stop_i), .sample_tick_i(sample_tick_i),
    .serializer_enable_o(a_ser), .deserializer_enable_o(a_deser),
    .mem_enable_o(a_en), .mem_rw_o(a_rw), .mem_addr_o(a_addr),
    .busy_o(a_busy), .error_o(a_err)
  );

  multi_clip_controller #(.ADDR_W(3)) dut_b (
    .clock_i(clock_i), .reset_i(reset_i), .clip_select_i(clip_select_i),
    .play_i(play_i), .record_i(record_i), .stop_i(stop_i), .sample_tick_i(sample_tick_i),
    .serializer_enable_o(b_ser), .deserializer_enable_o(b_deser),
    .mem_enable_o(b_en), .mem_rw_o(b_rw), .mem_addr_o(b_addr),
    .busy_o(b_busy), .error_o(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  // which: 0 play, 1 record, 2 stop. Returns just after the FSM has acted.
  task automatic press(input int which);
    case (which)
      0: play_i = 1'b1;
      1: record_i = 1'b1;
      default: stop_i = 1'b1;
    endcase
    cycles(4);
    play_i = 1'b0; record_i = 1'b0; stop_i = 1'b0;
  endtask

  task automatic do_tick(input string tag, input logic [3:0] en, input logic [15:0] addr,
                         input logic rw);
    sample_tick_i = 1'b1;
    cycles(1);
    sample_tick_i = 1'b0;
    check({tag, "_a_en"}, 32'(a_en), 32'(en));
    check({tag, "_a_addr"}, 32'(a_addr), 32'(addr));
    check({tag, "_a_rw"}, 32'(a_rw), 32'(rw));
    check({tag, "_b_en"}, 32'(b_en), 32'(en));
    check({tag, "_b_addr"}, 32'(b_addr), 32'(addr[2:0]));
    cycles(1);
    check({tag, "_a_en_clr"}, 32'(a_en), 32'd0);
  endtask

  initial begin
    reset_i = 1'b1; clip_select_i = 2'd0;
    play_i = 1'b0; record_i = 1'b0; stop_i = 1'b0; sample_tick_i = 1'b0;
    cycles(3);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_en", 32'(a_en), 32'd0);
    check("rst_deser", 32'(a_deser), 32'd0);
    reset_i = 1'b0;
    cycles(2);
    check("rst_idle", 32'(dut_a.state), 32'(IDLE));

    // Record clip 2 with five samples.
    clip_select_i = 2'd2;
    cycles(3);
    press(1);
    check("rec_deser", 32'(a_deser), 32'd1);
    check("rec_busy", 32'(a_busy), 32'd1);
    check("rec_rw", 32'(a_rw), 32'd1);
    check("rec_ser", 32'(a_ser), 32'd0);
    cycles(4);
    for (int i = 0; i < 5; i++) do_tick("rec2", 4'b0100, 16'(i), 1'b1);
    press(2);
    check("rec_stop_busy", 32'(a_busy), 32'd0);
    check("rec_stop_rw", 32'(a_rw), 32'd0);
    check("rec_stop_idle", 32'(dut_a.state), 32'(IDLE));
    check("len2_a", 32'(dut_a.length[2]), 32'd5);
    check("len2_b", 32'(dut_b.length[2]), 32'd5);
    cycles(4);

    // Play clip 2 back.
    press(0);
    check("play_ser", 32'(a_ser), 32'd1);
    check("play_busy", 32'(a_busy), 32'd1);
    check("play_rw", 32'(a_rw), 32'd0);
    cycles(4);
    for (int i = 0; i < 5; i++) do_tick("play2", 4'b0100, 16'(i), 1'b0);
`ifdef CLIP_LOOP_EN
    do_tick("loop2", 4'b0100, 16'd0, 1'b0);
    press(2);
`endif
    check("play_end_ser", 32'(a_ser), 32'd0);
    check("play_end_busy", 32'(a_busy), 32'd0);
    cycles(4);

    // Play an empty clip -> error; play ignored there; stop clears it.
    clip_select_i = 2'd1;
    cycles(4);
    press(0);
    check("err_set", 32'(a_err), 32'd1);
    check("err_busy", 32'(a_busy), 32'd0);
    check("err_ser", 32'(a_ser), 32'd0);
    cycles(4);
    press(0);
    check("err_play_ign", 32'(a_err), 32'd1);
    cycles(4);
    press(2);
    check("err_clr", 32'(a_err), 32'd0);
    cycles(4);

    // Play and record together -> record wins; play mid-record ignored.
    play_i = 1'b1; record_i = 1'b1;
    cycles(4);
    play_i = 1'b0; record_i = 1'b0;
    check("prio_deser", 32'(a_deser), 32'd1);
    check("prio_ser", 32'(a_ser), 32'd0);
    cycles(4);
    press(0);
    check("midplay_deser", 32'(a_deser), 32'd1);
    check("midplay_ser", 32'(a_ser), 32'd0);
    cycles(4);
    do_tick("rec1", 4'b0010, 16'd0, 1'b1);
    // Stop pulse coinciding with a tick: access first, then stop.
    stop_i = 1'b1;
    cycles(3);
    sample_tick_i = 1'b1;
    cycles(1);
    sample_tick_i = 1'b0; stop_i = 1'b0;
    check("coin_en", 32'(a_en), 32'h2);
    check("coin_addr", 32'(a_addr), 32'd1);
    check("coin_rw", 32'(a_rw), 32'd1);
    cycles(1);
    check("coin_deser", 32'(a_deser), 32'd0);
    check("len1_a", 32'(dut_a.length[1]), 32'd2);
    cycles(4);

    // Record 8 samples without stop: ADDR_W=3 instance wraps to IDLE.
    clip_select_i = 2'd0;
    cycles(4);
    press(1);
    cycles(4);
    for (int i = 0; i < 8; i++) do_tick("wrap", 4'b0001, 16'(i), 1'b1);
    check("wrap_b_busy", 32'(b_busy), 32'd0);
    check("wrap_b_deser", 32'(b_deser), 32'd0);
    check("wrap_b_len", 32'(dut_b.length[0]), 32'd8);
    check("wrap_a_busy", 32'(a_busy), 32'd1);
    press(2);
    check("wrap_a_stop", 32'(a_busy), 32'd0);
    check("wrap_a_len", 32'(dut_a.length[0]), 32'd8);
    cycles(4);

    // Reset in the middle of a recording of clip 3.
    clip_select_i = 2'd3;
    cycles(4);
    press(1);
    cycles(4);
    for (int i = 0; i < 3; i++) do_tick("rec3", 4'b1000, 16'(i), 1'b1);
    reset_i = 1'b1;
    cycles(1);
    check("mrst_busy", 32'(a_busy), 32'd0);
    check("mrst_deser", 32'(a_deser), 32'd0);
    check("mrst_rw", 32'(a_rw), 32'd0);
    check("mrst_en", 32'(a_en), 32'd0);
    check("mrst_addr", 32'(a_addr), 32'd0);
    check("mrst_len3", 32'(dut_a.length[3]), 32'd0);
    check("mrst_len2", 32'(dut_a.length[2]), 32'd0);
    reset_i = 1'b0;
    cycles(2);
    check("mrst_idle", 32'(dut_a.state), 32'(IDLE));
    cycles(3);
    press(0);
    check("mrst_play_err", 32'(a_err), 32'd1);
    check("mrst_b_err", 32'(b_err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
